// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates three register-file write requesters (0 = ALU, 1 = load,
// 2 = move/immediate) onto a single write port.  One write is accepted per
// cycle using a round-robin priority pointer.  The accepted write is
// registered and presented to the 3-to-8 write decoder and the register file
// data port one cycle later.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   reqN_valid/addr/data  write request from requester N (N = 0..2)
//   reqN_ready            combinational accept for requester N
//   wb_stall              blocks every grant in the current cycle
//   dec_enable, dec_addr  write decoder enable and address (registered)
//   wr_data               register file write data (registered)
//   grant_id              requester index of the presented write, 2'b11 idle
//   rr_ptr                debug view of the round-robin priority pointer
//
// Handshake: a write transfers in a cycle where reqN_valid && reqN_ready.
// Requesters hold valid/addr/data stable until they see ready; ready never
// waits on anything the requester does after seeing it, and nothing is
// latched from a request that was not accepted.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,

   input  logic              req2_valid,
   input  logic [ADDR_W-1:0] req2_addr,
   input  logic [DATA_W-1:0] req2_data,
   output logic              req2_ready,

   input  logic              wb_stall,

   output logic              dec_enable,
   output logic [ADDR_W-1:0] dec_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        grant_id,
   output logic [1:0]        rr_ptr
);

   localparam logic [1:0] IDLE_ID = 2'b11;

   // Reduce a 0..5 sum to 0..2 (mod 3).
   function automatic logic [1:0] wrap3(input logic [2:0] s);
      if (s >= 3'd3) begin
         wrap3 = 2'(s - 3'd3);
      end else begin
         wrap3 = s[1:0];
      end
   endfunction

   logic [1:0] ptr;
   logic [1:0] ptr_eff;
   logic [2:0] valid_vec;
   logic [1:0] cand;
   logic [1:0] win_idx;
   logic       found;
   logic       transfer;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // A pointer of 3 is never produced, but if it ever appears it is read as 0
   // and normalised on the next clock.
   assign ptr_eff   = (ptr == 2'd3) ? 2'd0 : ptr;
   assign valid_vec = {req2_valid, req1_valid, req0_valid};
   assign rr_ptr    = ptr;

   // Search P, P+1, P+2 (mod 3); first valid requester wins.
   always_comb begin
      found   = 1'b0;
      win_idx = 2'd0;
      cand    = 2'd0;
      for (int k = 0; k < 3; k++) begin
         cand = wrap3({1'b0, ptr_eff} + 3'(k));
         if (!found && valid_vec[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Stall and reset both suppress the grant in the same cycle.
   assign transfer   = found && !wb_stall && !rst;
   assign req0_ready = transfer && (win_idx == 2'd0);
   assign req1_ready = transfer && (win_idx == 2'd1);
   assign req2_ready = transfer && (win_idx == 2'd2);

   always_comb begin
      win_addr = req0_addr;
      win_data = req0_data;
      case (win_idx)
         2'd1: begin
            win_addr = req1_addr;
            win_data = req1_data;
         end
         2'd2: begin
            win_addr = req2_addr;
            win_data = req2_data;
         end
         default: begin
            win_addr = req0_addr;
            win_data = req0_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= 2'd0;
         dec_enable <= 1'b0;
         dec_addr   <= '0;
         wr_data    <= '0;
         grant_id   <= IDLE_ID;
      end else if (transfer) begin
         ptr        <= wrap3({1'b0, win_idx} + 3'd1);
         dec_enable <= 1'b1;
         dec_addr   <= win_addr;
         wr_data    <= win_data;
         grant_id   <= win_idx;
      end else begin
         // No transfer: pointer holds (stall included), address/data hold.
         ptr        <= ptr_eff;
         dec_enable <= 1'b0;
         grant_id   <= IDLE_ID;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   localparam int DATA_W = 10;
   localparam int ADDR_W = 3;
   localparam int W      = 2 + ADDR_W + DATA_W;

   logic              clk;
   logic              rst;
   logic              req0_valid, req1_valid, req2_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr, req2_addr;
   logic [DATA_W-1:0] req0_data, req1_data, req2_data;
   logic              req0_ready, req1_ready, req2_ready;
   logic              wb_stall;
   logic              dec_enable;
   logic [ADDR_W-1:0] dec_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        grant_id;
   logic [1:0]        rr_ptr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]      exp_q[$];
   logic              rst_q = 1'b1;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DATA_W-1:0] last_data = '0;

   regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(req2_ready),
      .wb_stall(wb_stall),
      .dec_enable(dec_enable), .dec_addr(dec_addr), .wr_data(wr_data),
      .grant_id(grant_id), .rr_ptr(rr_ptr)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) rst_q = rst;

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_q) begin
         last_addr = '0;
         last_data = '0;
      end
      if (dec_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(dec_enable), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_grant", 32'(grant_id), 32'(e[W-1 -: 2]));
            check("wr_addr",  32'(dec_addr), 32'(e[DATA_W +: ADDR_W]));
            check("wr_data",  32'(wr_data),  32'(e[DATA_W-1:0]));
            last_addr = e[DATA_W +: ADDR_W];
            last_data = e[DATA_W-1:0];
         end
      end else begin
         check("idle_enable", 32'(dec_enable), 32'd0);
         check("idle_grant",  32'(grant_id),   32'd3);
         check("hold_addr",   32'(dec_addr),   32'(last_addr));
         check("hold_data",   32'(wr_data),    32'(last_data));
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle: check readies at mid-cycle, record the expected write, advance.
   task automatic cycle(input string tag, input logic [2:0] exp_rdy);
      @(negedge clk);
      check({tag, "_ready"}, 32'({req2_ready, req1_ready, req0_ready}), 32'(exp_rdy));
      case (exp_rdy)
         3'b001: exp_q.push_back({2'd0, req0_addr, req0_data});
         3'b010: exp_q.push_back({2'd1, req1_addr, req1_data});
         3'b100: exp_q.push_back({2'd2, req2_addr, req2_data});
         default: ;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req2_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1;
      wb_stall = 1'b0;
      req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 10'h155;
      req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
      req2_valid = 1'b0; req2_addr = '0;   req2_data = '0;

      // Reset state, request offered during reset is refused.
      repeat (2) @(posedge clk);
      #1;
      cycle("reset", 3'b000);
      check("reset_ptr", 32'(rr_ptr), 32'd0);
      rst = 1'b0;
      idle_all();

      // Single request from requester 1.
      req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 10'h2A5;
      cycle("single", 3'b010);
      idle_all();
      cycle("single_after", 3'b000);
      check("single_ptr", 32'(rr_ptr), 32'd2);

      // Continuous requests from all three after reset: 0,1,2,0,1,2.
      reset_pulse();
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 10'h011;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 10'h022;
      req2_valid = 1'b1; req2_addr = 3'd3; req2_data = 10'h033;
      for (int i = 0; i < 6; i++) begin
         cycle("rr_all", 3'(1 << (i % 3)));
         case (i % 3)
            0: begin req0_data = 10'($urandom_range(0, 1023)); req0_addr = 3'($urandom_range(0, 7)); end
            1: begin req1_data = 10'($urandom_range(0, 1023)); req1_addr = 3'($urandom_range(0, 7)); end
            default: begin req2_data = 10'($urandom_range(0, 1023)); req2_addr = 3'($urandom_range(0, 7)); end
         endcase
      end
      idle_all();
      cycle("rr_drain", 3'b000);
      check("rr_ptr_wrap", 32'(rr_ptr), 32'd0);

      // Move pointer to 2, then req0+req1 valid: req0 wins, then req1.
      req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 10'h0A4;
      cycle("p2_setup", 3'b010);
      check("p2_ptr", 32'(rr_ptr), 32'd2);
      req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 10'h306;
      req1_addr = 3'd0; req1_data = 10'h1B0;
      cycle("p2_first", 3'b001);
      check("p2_ptr_after", 32'(rr_ptr), 32'd1);
      req0_valid = 1'b0;
      cycle("p2_second", 3'b010);
      idle_all();

      // Stall three cycles with req0 and req2 valid; pointer is 2.
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 10'h2C1;
      req2_valid = 1'b1; req2_addr = 3'd7; req2_data = 10'h0F7;
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle("stall", 3'b000);
         check("stall_ptr", 32'(rr_ptr), 32'd2);
      end
      wb_stall = 1'b0;
      cycle("stall_release", 3'b100);
      req2_valid = 1'b0;
      cycle("stall_next", 3'b001);
      idle_all();

      // Same address from req0 then req1: pointer to 0 first via req2.
      req2_valid = 1'b1; req2_addr = 3'd2; req2_data = 10'h222;
      cycle("same_setup", 3'b100);
      req2_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 10'h001;
      req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 10'h3FF;
      cycle("same_first", 3'b001);
      req0_valid = 1'b0;
      cycle("same_second", 3'b010);
      idle_all();
      check("pre_rst_ptr", 32'(rr_ptr), 32'd2);

      // Reset in the cycle a request would transfer.
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 10'h333;
      rst = 1'b1;
      cycle("rst_xfer", 3'b000);
      rst = 1'b0;
      req0_valid = 1'b0;
      cycle("rst_after", 3'b000);
      check("rst_after_ptr", 32'(rr_ptr), 32'd0);

      cycle("final_idle", 3'b000);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
